// File: rtl/pulse_sequencer.sv
// pulse_sequencer: arms on a synchronised rising edge of start_in and emits a
// single-shot or periodic pulse train from latched delay/width/period words.
// Ports:
//   clk_clk, reset_reset           fabric clock, asynchronous active-high reset
//   start_in                       level from the start PIO (rise arms, low aborts)
//   delay_in, width_in, period_in  timing words in clk_clk cycles (period 0 = single-shot)
//   pulse_out, busy, done          registered decodes of the sequencer state
//   pulse_count                    pulses emitted since the last arm, saturating
// Latency: leaves IDLE SYNC_STAGES edges after start_in is first sampled high;
// pulse_out rises delay cycles after that.
// Flow control: none; the timing words are sampled once per arm.

module pulse_sequencer #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth on start_in, legal 2..4
    parameter int CNT_W       = 32   // width of timing words and counters
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             start_in,
    input  logic [CNT_W-1:0] delay_in,
    input  logic [CNT_W-1:0] width_in,
    input  logic [CNT_W-1:0] period_in,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    // ------------------------------------------------------------------
    // start_in synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   start_s;
    logic                   start_s_d_q;
    // prime_q fills with ones after reset. Its top bit says that start_s_d_q
    // holds a genuine sample of start_in rather than a reset value, so a start
    // level held high across reset is not mistaken for a fresh rising edge.
    logic [SYNC_STAGES:0]   prime_q;
    logic                   rise;

    assign start_s = sync_q[SYNC_STAGES-1];
    assign rise    = start_s & ~start_s_d_q & prime_q[SYNC_STAGES];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q      <= '0;
            start_s_d_q <= 1'b0;
            prime_q     <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], start_in};
            start_s_d_q <= start_s;
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // cycles remaining in state, minus one
    logic [CNT_W-1:0] width_q, width_d;   // latched pulse width
    logic [CNT_W-1:0] period_q, period_d; // latched repetition period
    logic [CNT_W-1:0] count_q, count_d;   // pulses since arm
    logic             pulse_q, busy_q, done_q;

    logic [CNT_W-1:0] count_inc;   // saturating increment of pulse_count
    logic [CNT_W-1:0] low_reload;  // LOW length minus one, never below one cycle

    assign count_inc  = (count_q == '1) ? count_q : count_q + ONE;
    // period <= width still gets a single low cycle so pulses never merge.
    assign low_reload = (period_q > width_q) ? (period_q - width_q - ONE) : ZERO;

    // The delay word is consumed straight into the counter on arm; only width
    // and period are needed again later, so only they are held.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        period_d = period_q;
        count_d  = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    width_d  = width_in;
                    period_d = period_in;
                    count_d  = ZERO;
                    if (width_in == ZERO) begin
                        state_d = ST_DONE;
                        cnt_d   = ZERO;
                    end else if (delay_in != ZERO) begin
                        state_d = ST_DELAY;
                        cnt_d   = delay_in - ONE;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = width_in - ONE;
                        count_d = ONE;
                    end
                end
            end

            ST_DELAY: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end else if (cnt_q == ZERO) begin
                    state_d = ST_HIGH;
                    cnt_d   = width_q - ONE;
                    count_d = count_inc;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            ST_HIGH: begin
                // An abort is only honoured once the pulse has run its full width.
                if (cnt_q != ZERO) begin
                    cnt_d = cnt_q - ONE;
                end else if (!start_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end else if (period_q == ZERO) begin
                    state_d = ST_DONE;
                    cnt_d   = ZERO;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = low_reload;
                end
            end

            ST_LOW: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end else if (cnt_q == ZERO) begin
                    state_d = ST_HIGH;
                    cnt_d   = width_q - ONE;
                    count_d = count_inc;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            ST_DONE: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            period_q <= period_d;
            count_q  <= count_d;
            // Outputs decode the next state so they change on the same edge
            // as the state register, straight from flops.
            pulse_q  <= (state_d == ST_HIGH);
            busy_q   <= (state_d == ST_DELAY) || (state_d == ST_HIGH) || (state_d == ST_LOW);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign pulse_out   = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_count = count_q;

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Timing engine behind the pulse PIOs. It samples the start PIO, latches the delay/width/period words, and sequences a single-shot or periodic pulse train on the 100 MHz fabric clock. It sits between the HPS-driven PIO exports and the FPGA pulse output pin, and reports status back for a read-back PIO.

Parameters:
SYNC_STAGES, 2, synchroniser depth on start_in (legal 2..4)
CNT_W, 32, width of delay/width/period words and internal counter

Ports:
clk_clk  in  1  fabric clock (100 MHz PLL output)
reset_reset  in  1  asynchronous, active-high reset
start_in  in  1  level from pulse_start PIO; rising edge arms a run, low aborts it
delay_in  in  CNT_W  cycles from arm to first pulse rising edge
width_in  in  CNT_W  pulse high time, cycles
period_in  in  CNT_W  pulse repetition period, cycles; 0 = single-shot
pulse_out  out  1  registered pulse output
busy  out  1  high in DELAY, HIGH or LOW states
done  out  1  high in DONE state
pulse_count  out  CNT_W  pulses emitted since last arm, saturating

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-high (clk_clk / reset_reset).
- Reset: state IDLE; pulse_out=0, busy=0, done=0, pulse_count=0; sync flops and edge-detect flop=0; latched config=0.
- start_in passes through SYNC_STAGES flops to give start_s; rise = start_s & ~start_s_d.
- Latched config: delay_in, width_in and period_in are captured on rise only. Later input changes are ignored until the next rise.
- States: IDLE, DELAY, HIGH, LOW, DONE. A single down-counter is reloaded on every state entry.
- IDLE, on rise:
  - Clear pulse_count.
  - width=0: go to DONE (no pulse emitted).
  - Else delay>0: go to DELAY.
  - Else: go to HIGH.
- DELAY: lasts exactly delay cycles, then HIGH.
- HIGH:
  - pulse_out=1 for exactly width cycles.
  - pulse_count increments on entry; it saturates at all-ones.
- End of HIGH:
  - period=0: go to DONE.
  - Otherwise go to LOW, with low_len = period-width if period>width, else 1. A minimum of one low cycle is always enforced.
- LOW: lasts low_len cycles, then HIGH.
- DONE: done=1; hold until start_s=0, then IDLE. A new run needs start low then high.
- Abort (start_s=0 while running):
  - In DELAY or LOW: go to IDLE on the next edge.
  - In HIGH: finish the full width, then IDLE. No truncated pulses.
  - pulse_count is retained.
- Latency: if start_in is first sampled 1 at edge N, the state leaves IDLE at edge N+SYNC_STAGES. pulse_out first rises at edge N+SYNC_STAGES+delay.
- Timing: period measured rising-to-rising = max(period, width+1) when period≠0.
- pulse_out, busy and done are registered decodes of the next state: no glitches, and they update on the same edge as the state.
- Arithmetic: all counters are unsigned CNT_W. delay=all-ones must work without wrap.
- Reset mid-pulse: pulse_out falls asynchronously and immediately.
- rise cannot occur outside IDLE/DONE-after-low, so no simultaneous-arm handling is needed.

Test Plan:
- Single-shot: delay=10, width=5, period=0; start 0→1 at edge N → pulse_out high on edges N+12..N+16, low after; done=1 from N+17; pulse_count=1; busy low after HIGH.
- Periodic: delay=0, width=3, period=10, start held → pulse_out rises at N+2, N+12, N+22 …, each 3 cycles wide; pulse_count counts 1,2,3.
- Degenerate:
  - width=0 → DONE, no pulse, count 0.
  - width=8, period=4 → 8 high, 1 low, repeating (period 9).
- Abort:
  - Drop start mid-LOW → IDLE within SYNC_STAGES+1 cycles, pulse_out stays 0.
  - Drop mid-HIGH (width=20) → pulse completes full 20 cycles, then IDLE.
- Config isolation: change width_in 5→50 during a periodic run → pulses stay 5 wide. Re-arm (start low→high) → 50 wide, pulse_count restarts at 1.
- Reset: assert reset_reset asynchronously during HIGH → pulse_out, busy and pulse_count go 0 immediately. After release with start held high, no pulse until a fresh rising edge.
